// File: rtl/ddr_pkg.sv
// ============================================================================
// ddr_pkg : shared types and constants for the DDR4 command decoder
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package ddr_pkg;

  typedef enum logic [3:0] {
    DES  = 4'd0,
    NOP  = 4'd1,
    ACT  = 4'd2,
    MRS  = 4'd3,
    REF  = 4'd4,
    PRE  = 4'd5,
    PREA = 4'd6,
    WR   = 4'd7,
    WRA  = 4'd8,
    RD   = 4'd9,
    RDA  = 4'd10,
    ZQCL = 4'd11,
    RFU  = 4'd12
  } command_type;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } bank_state_t;

  typedef logic [2:0] err_code_t;

  localparam err_code_t ERR_NONE     = 3'd0;
  localparam err_code_t ERR_ACT_OPEN = 3'd1;
  localparam err_code_t ERR_RW_IDLE  = 3'd2;
  localparam err_code_t ERR_REF_OPEN = 3'd3;
  localparam err_code_t ERR_TRCD     = 3'd4;
  localparam err_code_t ERR_RFU      = 3'd5;

  localparam int TRCD_DEFAULT = 11;

endpackage

`default_nettype wire

// File: rtl/ddr_bank_tracker.sv
// ============================================================================
// ddr_bank_tracker : 16 per-bank IDLE/ACTIVE FSMs plus optional tRCD counters
// (counters built only with CMD_DECODE_TRCD_CHK_EN). Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ddr_bank_tracker
  import ddr_pkg::*;
#(
  parameter int TRCD = TRCD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  command_type cmd,
  input  logic [3:0]  bank,
  output logic [15:0] bank_open,
  output logic        trcd_met
);

`ifdef CMD_DECODE_TRCD_CHK_EN
  localparam int CNT_W = $clog2(TRCD + 1);
  logic [16*CNT_W-1:0] cnt_flat;
`endif

  for (genvar i = 0; i < 16; i++) begin : g_bank
    bank_state_t state;
    logic        hit;

    assign hit = (bank == 4'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
      end else if (cmd == PREA) begin
        state <= IDLE;
      end else if (hit) begin
        case (cmd)
          ACT:          state <= ACTIVE;
          PRE, RDA, WRA: state <= IDLE;
          default:      state <= state;
        endcase
      end
    end

    assign bank_open[i] = (state == ACTIVE);

`ifdef CMD_DECODE_TRCD_CHK_EN
    logic [CNT_W-1:0] cnt;

    // A repeated ACT to an open bank is an error and must not restart tRCD
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= CNT_W'(TRCD);
      end else if (hit && cmd == ACT && state == IDLE) begin
        cnt <= '0;
      end else if (cnt != CNT_W'(TRCD)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign cnt_flat[i*CNT_W +: CNT_W] = cnt;
`endif
  end

`ifdef CMD_DECODE_TRCD_CHK_EN
  assign trcd_met = (cnt_flat[int'(bank)*CNT_W +: CNT_W] >= CNT_W'(TRCD - 1));
`else
  assign trcd_met = 1'b1;
`endif

endmodule

`default_nettype wire

// File: rtl/ddr_cmd_decode.sv
// ============================================================================
// ddr_cmd_decode : registered DDR4 pin decode with bank tracking and protocol
// error reporting; tRCD check enabled by CMD_DECODE_TRCD_CHK_EN. Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ddr_cmd_decode
  import ddr_pkg::*;
#(
  parameter int TRCD = TRCD_DEFAULT
) (
  input  logic        CK_c,
  input  logic        reset,
  input  logic        cs_n,
  input  logic        act_n,
  input  logic        RAS_n_A16,
  input  logic        CAS_n_A15,
  input  logic        WE_n_A14,
  input  logic        A12_BC_n,
  input  logic        A17,
  input  logic        A13,
  input  logic        A11,
  input  logic        A10_AP,
  input  logic [1:0]  bg_addr,
  input  logic [1:0]  ba_addr,
  input  logic [9:0]  A9_A0,
  output logic        cmd_valid,
  output command_type cmd_out,
  output logic [1:0]  cmd_bg,
  output logic [1:0]  cmd_ba,
  output logic [13:0] cmd_row,
  output logic [9:0]  cmd_col,
  output logic [15:0] bank_open,
  output logic        mr_wr,
  output logic [2:0]  mr_sel,
  output logic [13:0] mr_data,
  output logic        proto_err,
  output logic [2:0]  err_code
);

  command_type cmd_d;
  err_code_t   err_d;
  logic [13:0] row_d;
  logic [3:0]  bank_d;
  logic        trcd_met;
  logic        is_rw;
  logic        is_rw_plain;
  logic        unused_a17;

  assign unused_a17 = A17;
  assign row_d      = {A13, A12_BC_n, A11, A10_AP, A9_A0};
  assign bank_d     = {bg_addr, ba_addr};

  always_comb begin
    cmd_d = DES;
    if (!cs_n) begin
      if (!act_n) begin
        cmd_d = ACT;
      end else begin
        case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
          3'b000:  cmd_d = MRS;
          3'b001:  cmd_d = REF;
          3'b010:  cmd_d = A10_AP ? PREA : PRE;
          3'b100:  cmd_d = A10_AP ? WRA  : WR;
          3'b101:  cmd_d = A10_AP ? RDA  : RD;
          3'b110:  cmd_d = ZQCL;
          3'b111:  cmd_d = NOP;
          default: cmd_d = RFU;
        endcase
      end
    end
  end

  assign is_rw       = (cmd_d == RD) || (cmd_d == WR) || (cmd_d == RDA) || (cmd_d == WRA);
  assign is_rw_plain = (cmd_d == RD) || (cmd_d == WR);

  // Checks use bank state before this edge's update; chain order sets priority
  always_comb begin
    err_d = ERR_NONE;
    if (cmd_d == RFU)
      err_d = ERR_RFU;
    else if (is_rw && !bank_open[bank_d])
      err_d = ERR_RW_IDLE;
    else if (cmd_d == ACT && bank_open[bank_d])
      err_d = ERR_ACT_OPEN;
    else if (is_rw_plain && !trcd_met)
      err_d = ERR_TRCD;
    else if ((cmd_d == REF || cmd_d == ZQCL) && (bank_open != 16'h0))
      err_d = ERR_REF_OPEN;
  end

  ddr_bank_tracker #(
    .TRCD(TRCD)
  ) u_tracker (
    .clk      (CK_c),
    .rst      (reset),
    .cmd      (cmd_d),
    .bank     (bank_d),
    .bank_open(bank_open),
    .trcd_met (trcd_met)
  );

  always_ff @(posedge CK_c or posedge reset) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_out   <= DES;
      cmd_bg    <= '0;
      cmd_ba    <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      mr_wr     <= 1'b0;
      mr_sel    <= '0;
      mr_data   <= '0;
      proto_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      cmd_valid <= (cmd_d != DES) && (cmd_d != NOP) && (cmd_d != RFU);
      cmd_out   <= cmd_d;
      cmd_bg    <= bg_addr;
      cmd_ba    <= ba_addr;
      cmd_row   <= row_d;
      cmd_col   <= A9_A0;
      mr_wr     <= (cmd_d == MRS);
      mr_sel    <= {bg_addr[0], ba_addr};
      mr_data   <= row_d;
      proto_err <= (err_d != ERR_NONE);
      err_code  <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ddr_cmd_decode.sv
// Scoreboard bench for ddr_cmd_decode: reference model predicts every registered
// output cycle by cycle; directed tasks add targeted inline checks.
`default_nettype none
`timescale 1ns/1ps

module tb_ddr_cmd_decode;
  import ddr_pkg::*;

  localparam int TRCD = TRCD_DEFAULT;

  logic        CK_c = 1'b0;
  logic        reset = 1'b1;
  logic        cs_n = 1'b1, act_n = 1'b1;
  logic        RAS_n_A16 = 1'b1, CAS_n_A15 = 1'b1, WE_n_A14 = 1'b1;
  logic        A12_BC_n = 1'b0, A17 = 1'b0, A13 = 1'b0, A11 = 1'b0, A10_AP = 1'b0;
  logic [1:0]  bg_addr = '0, ba_addr = '0;
  logic [9:0]  A9_A0 = '0;
  logic        cmd_valid;
  command_type cmd_out;
  logic [1:0]  cmd_bg, cmd_ba;
  logic [13:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [15:0] bank_open;
  logic        mr_wr;
  logic [2:0]  mr_sel;
  logic [13:0] mr_data;
  logic        proto_err;
  logic [2:0]  err_code;

  ddr_cmd_decode #(.TRCD(TRCD)) dut (
    .CK_c(CK_c), .reset(reset), .cs_n(cs_n), .act_n(act_n),
    .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
    .A12_BC_n(A12_BC_n), .A17(A17), .A13(A13), .A11(A11), .A10_AP(A10_AP),
    .bg_addr(bg_addr), .ba_addr(ba_addr), .A9_A0(A9_A0),
    .cmd_valid(cmd_valid), .cmd_out(cmd_out), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .bank_open(bank_open),
    .mr_wr(mr_wr), .mr_sel(mr_sel), .mr_data(mr_data),
    .proto_err(proto_err), .err_code(err_code)
  );

  always #5 CK_c = ~CK_c;

  typedef struct {
    logic        valid;
    command_type cmd;
    logic [1:0]  bg, ba;
    logic [13:0] row;
    logic [9:0]  col;
    logic [15:0] open;
    logic        mr_wr;
    logic [2:0]  mr_sel;
    logic [13:0] mr_data;
    logic        err;
    logic [2:0]  code;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_open = '0;
  int          m_cnt[16];

  // Encode a command onto the pins and predict the DUT response one edge later
  task automatic drive_now(input command_type c, input logic [1:0] bg, input logic [1:0] ba,
                           input logic [13:0] a);
    exp_t        e;
    logic [3:0]  b;
    logic [2:0]  code;
    logic [13:0] adr;
    logic        rw;
    b   = {bg, ba};
    adr = a;
    if (c == RD || c == WR || c == PRE) adr[10] = 1'b0;
    if (c == RDA || c == WRA || c == PREA) adr[10] = 1'b1;
    cs_n  = (c == DES);
    act_n = (c != ACT);
    case (c)
      ACT, MRS:  {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b000;
      REF:       {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b001;
      PRE, PREA: {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b010;
      RFU:       {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b011;
      WR, WRA:   {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b100;
      RD, RDA:   {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b101;
      ZQCL:      {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b110;
      default:   {RAS_n_A16, CAS_n_A15, WE_n_A14} = 3'b111;
    endcase
    {A13, A12_BC_n, A11, A10_AP, A9_A0} = adr;
    A17 = 1'b0;
    bg_addr = bg;
    ba_addr = ba;

    rw   = (c == RD || c == WR || c == RDA || c == WRA);
    code = 3'd0;
    if (c == RFU) code = 3'd5;
    else if (rw && !m_open[b]) code = 3'd2;
    else if (c == ACT && m_open[b]) code = 3'd1;
`ifdef CMD_DECODE_TRCD_CHK_EN
    else if ((c == RD || c == WR) && m_cnt[b] < TRCD - 1) code = 3'd4;
`endif
    else if ((c == REF || c == ZQCL) && m_open != 16'h0) code = 3'd3;

    for (int i = 0; i < 16; i++)
      if (m_cnt[i] < TRCD) m_cnt[i]++;
    if (c == PREA) m_open = '0;
    else if (c == ACT && !m_open[b]) begin
      m_open[b] = 1'b1;
      m_cnt[b]  = 0;
    end else if (c == PRE || c == RDA || c == WRA) m_open[b] = 1'b0;

    e.valid   = (c != DES && c != NOP && c != RFU);
    e.cmd     = c;
    e.bg      = bg;
    e.ba      = ba;
    e.row     = adr;
    e.col     = adr[9:0];
    e.open    = m_open;
    e.mr_wr   = (c == MRS);
    e.mr_sel  = {bg[0], ba};
    e.mr_data = adr;
    e.err     = (code != 3'd0);
    e.code    = code;
    sb.push_back(e);
  endtask

  task automatic cyc(input command_type c, input logic [1:0] bg, input logic [1:0] ba,
                     input logic [13:0] a);
    @(negedge CK_c);
    drive_now(c, bg, ba, a);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(DES, 2'd0, 2'd0, 14'h0);
  endtask

  task automatic settle();
    @(posedge CK_c);
    #3;
  endtask

  task automatic model_reset();
    sb.delete();
    m_open = '0;
    for (int i = 0; i < 16; i++) m_cnt[i] = TRCD;
  endtask

  always @(posedge CK_c) begin
    #2;
    if (!reset && sb.size() > 0) begin
      mon_e = sb.pop_front();
      vectors += 5;
      if ({cmd_valid, cmd_out} !== {mon_e.valid, mon_e.cmd}) begin
        miscompares++;
        $display("FAIL sb_cmd: valid/cmd got %0b/%0d expected %0b/%0d", cmd_valid, cmd_out, mon_e.valid, mon_e.cmd);
      end
      if ({cmd_bg, cmd_ba, cmd_row, cmd_col} !== {mon_e.bg, mon_e.ba, mon_e.row, mon_e.col}) begin
        miscompares++;
        $display("FAIL sb_addr: bg/ba/row/col got %0d/%0d/%h/%h expected %0d/%0d/%h/%h",
                 cmd_bg, cmd_ba, cmd_row, cmd_col, mon_e.bg, mon_e.ba, mon_e.row, mon_e.col);
      end
      if (bank_open !== mon_e.open) begin
        miscompares++;
        $display("FAIL sb_bank_open: got %h expected %h", bank_open, mon_e.open);
      end
      if ({mr_wr, mr_sel, mr_data} !== {mon_e.mr_wr, mon_e.mr_sel, mon_e.mr_data}) begin
        miscompares++;
        $display("FAIL sb_mrs: wr/sel/data got %0b/%0d/%h expected %0b/%0d/%h",
                 mr_wr, mr_sel, mr_data, mon_e.mr_wr, mon_e.mr_sel, mon_e.mr_data);
      end
      if ({proto_err, err_code} !== {mon_e.err, mon_e.code}) begin
        miscompares++;
        $display("FAIL sb_err: err/code got %0b/%0d expected %0b/%0d", proto_err, err_code, mon_e.err, mon_e.code);
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge CK_c);
    #1;
    vectors++;
    if ({cmd_valid, cmd_out, cmd_row, cmd_col, bank_open, mr_wr, proto_err, err_code} !==
        {1'b0, DES, 14'h0, 10'h0, 16'h0, 1'b0, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_values: valid=%0b cmd=%0d row=%h open=%h err=%0b code=%0d expected all zero/DES",
               cmd_valid, cmd_out, cmd_row, bank_open, proto_err, err_code);
    end
    @(negedge CK_c);
    reset = 1'b0;
    drive_now(ACT, 2'd0, 2'd1, 14'h0123);
    settle();
    vectors++;
    if (cmd_out !== ACT || bank_open[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL first_edge_after_reset: cmd=%0d open=%h expected ACT with bank 1 open", cmd_out, bank_open);
    end
    cyc(PRE, 2'd0, 2'd1, 14'h0);
  endtask

  task automatic test_act_rd();
    cyc(ACT, 2'd1, 2'd2, 14'h1ABC);
    settle();
    vectors++;
    if (cmd_out !== ACT || cmd_row !== 14'h1ABC || bank_open[6] !== 1'b1 || proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL act_bank6: cmd=%0d row=%h open=%h err=%0b expected ACT 1abc bank6 open no err",
               cmd_out, cmd_row, bank_open, proto_err);
    end
    idle(10);
    cyc(RD, 2'd1, 2'd2, 14'h0005);
    settle();
    vectors++;
    if (cmd_out !== RD || cmd_col !== 10'h005 || proto_err !== 1'b0 || cmd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_after_trcd: cmd=%0d col=%h err=%0b code=%0d expected RD col 005 no err",
               cmd_out, cmd_col, proto_err, err_code);
    end
  endtask

  task automatic test_trcd();
    logic [3:0] exp_code;
`ifdef CMD_DECODE_TRCD_CHK_EN
    exp_code = 4'd4;
`else
    exp_code = 4'd0;
`endif
    cyc(ACT, 2'd0, 2'd0, 14'h0042);
    idle(2);
    cyc(WR, 2'd0, 2'd0, 14'h0001);
    settle();
    vectors++;
    if ({1'b0, err_code} !== exp_code || proto_err !== (exp_code != 0)) begin
      miscompares++;
      $display("FAIL wr_early: err=%0b code=%0d expected code %0d", proto_err, err_code, exp_code);
    end
    cyc(PRE, 2'd0, 2'd0, 14'h0);
    cyc(ACT, 2'd0, 2'd0, 14'h0042);
    idle(9);
    cyc(RD, 2'd0, 2'd0, 14'h0002);
    settle();
    vectors++;
    if ({1'b0, err_code} !== exp_code) begin
      miscompares++;
      $display("FAIL rd_one_short: code=%0d expected %0d", err_code, exp_code);
    end
    cyc(RD, 2'd0, 2'd0, 14'h0003);
    settle();
    vectors++;
    if (proto_err !== 1'b0 || err_code !== 3'd0) begin
      miscompares++;
      $display("FAIL rd_at_trcd: err=%0b code=%0d expected no error", proto_err, err_code);
    end
    cyc(PRE, 2'd0, 2'd0, 14'h0);
  endtask

  task automatic test_rda();
    cyc(ACT, 2'd0, 2'd3, 14'h0777);
    idle(10);
    cyc(RDA, 2'd0, 2'd3, 14'h0010);
    settle();
    vectors++;
    if (cmd_out !== RDA || bank_open[3] !== 1'b0 || proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rda_close: cmd=%0d open=%h err=%0b expected RDA bank3 closed", cmd_out, bank_open, proto_err);
    end
    cyc(RD, 2'd0, 2'd3, 14'h0011);
    settle();
    vectors++;
    if (err_code !== 3'd2 || proto_err !== 1'b1 || cmd_valid !== 1'b1 || cmd_out !== RD) begin
      miscompares++;
      $display("FAIL rd_idle: cmd=%0d valid=%0b code=%0d expected RD valid code 2", cmd_out, cmd_valid, err_code);
    end
  endtask

  task automatic test_mrs();
    cyc(MRS, 2'd0, 2'd2, 14'h0124);
    settle();
    vectors++;
    if (mr_wr !== 1'b1 || mr_sel !== 3'd2 || mr_data !== 14'h0124 || cmd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mrs: wr=%0b sel=%0d data=%h valid=%0b expected 1/2/0124/1", mr_wr, mr_sel, mr_data, cmd_valid);
    end
    cyc(DES, 2'd0, 2'd0, 14'h0);
    settle();
    vectors++;
    if (mr_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL mrs_pulse: wr=%0b expected 0", mr_wr);
    end
  endtask

  task automatic test_refresh();
    cyc(ACT, 2'd3, 2'd3, 14'h0100);
    cyc(REF, 2'd0, 2'd0, 14'h0);
    settle();
    vectors++;
    if (err_code !== 3'd3 || proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL ref_open: code=%0d expected 3", err_code);
    end
    cyc(PREA, 2'd0, 2'd0, 14'h0);
    cyc(REF, 2'd0, 2'd0, 14'h0);
    settle();
    vectors++;
    if (bank_open !== 16'h0 || proto_err !== 1'b0 || err_code !== 3'd0 || cmd_out !== REF) begin
      miscompares++;
      $display("FAIL ref_closed: open=%h code=%0d expected 0000 no err", bank_open, err_code);
    end
    cyc(PREA, 2'd1, 2'd1, 14'h0);
    settle();
    vectors++;
    if (proto_err !== 1'b0 || cmd_valid !== 1'b1 || cmd_out !== PREA) begin
      miscompares++;
      $display("FAIL prea_none_open: cmd=%0d valid=%0b err=%0b expected PREA valid no err", cmd_out, cmd_valid, proto_err);
    end
  endtask

  task automatic test_errors();
    cyc(ACT, 2'd1, 2'd1, 14'h0200);
    cyc(ACT, 2'd1, 2'd1, 14'h0300);
    settle();
    vectors++;
    if (err_code !== 3'd1 || bank_open[5] !== 1'b1 || cmd_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL act_open: code=%0d open=%h expected code 1 bank5 open", err_code, bank_open);
    end
    cyc(RFU, 2'd0, 2'd0, 14'h0);
    settle();
    vectors++;
    if (err_code !== 3'd5 || cmd_valid !== 1'b0 || cmd_out !== RFU) begin
      miscompares++;
      $display("FAIL rfu: cmd=%0d valid=%0b code=%0d expected RFU invalid code 5", cmd_out, cmd_valid, err_code);
    end
    cyc(NOP, 2'd0, 2'd0, 14'h0);
    settle();
    vectors++;
    if (cmd_valid !== 1'b0 || cmd_out !== NOP || proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL nop: cmd=%0d valid=%0b expected NOP invalid", cmd_out, cmd_valid);
    end
    cyc(PREA, 2'd0, 2'd0, 14'h0);
  endtask

  task automatic test_back_to_back();
    command_type c;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       c = ACT;
        1:       c = DES;
        default: c = command_type'($urandom_range(0, 12));
      endcase
      cyc(c, 2'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 14'($urandom));
    end
    idle(1);
    settle();
  endtask

  task automatic test_reset_mid();
    cyc(ACT, 2'd2, 2'd1, 14'h0055);
    cyc(ACT, 2'd0, 2'd2, 14'h0066);
    cyc(MRS, 2'd1, 2'd3, 14'h3FFF);
    settle();
    reset = 1'b1;
    #1;
    vectors++;
    if ({cmd_valid, cmd_out, cmd_bg, cmd_ba, cmd_row, cmd_col, bank_open, mr_wr, mr_sel, mr_data, proto_err, err_code} !==
        {1'b0, DES, 2'd0, 2'd0, 14'h0, 10'h0, 16'h0, 1'b0, 3'd0, 14'h0, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL async_reset: valid=%0b cmd=%0d row=%h open=%h mr=%0b/%h code=%0d expected reset values",
               cmd_valid, cmd_out, cmd_row, bank_open, mr_wr, mr_data, err_code);
    end
    model_reset();
    repeat (2) @(posedge CK_c);
    @(negedge CK_c);
    reset = 1'b0;
    drive_now(RD, 2'd2, 2'd1, 14'h0004);
    settle();
    vectors++;
    if (err_code !== 3'd2) begin
      miscompares++;
      $display("FAIL rd_after_reset: code=%0d expected 2", err_code);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_act_rd();
    test_trcd();
    test_rda();
    test_mrs();
    test_refresh();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    idle(2);
    settle();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
